// File: rtl/top3_dedup_initiator.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// top3_dedup_initiator
//
// Producer side of the top-3 duplicate-check handshake. One frame of
// NUM_CLASSES scores arrives in class-index order. The three highest-scoring
// class indices are kept in sorted slots. At the end of the frame a one-cycle
// request goes to the duplicate checker, with the current and previous top-3
// held stable. A "new" verdict emits tops[0] as a character and commits the
// current top-3 as the previous one. A "not new" verdict drops the frame.
// A checker that never answers is abandoned after TIMEOUT cycles, and the
// sticky o_timeout flag is set.
//
// Ports
//   i_clk             clock
//   i_rst_n           asynchronous reset, active-high (historic name)
//   i_score_valid     score beat valid
//   i_score           score for the class index given by the internal beat count
//   o_score_ready     beat accepted when i_score_valid & o_score_ready
//   o_dedup_next      one-cycle request pulse to the duplicate checker
//   o_tops[0:2]       current top-3 class indices, [0] = highest score
//   o_prev_tops[0:2]  last committed top-3 class indices
//   i_dedup_finished  checker done, one-cycle pulse
//   i_dedup_next      checker verdict, 1 = new (valid with i_dedup_finished)
//   o_char_valid      emitted character valid
//   o_char            emitted class index
//   i_char_ready      downstream accepts when o_char_valid & i_char_ready
//   o_timeout         sticky, set when a request is abandoned
// -----------------------------------------------------------------------------
module top3_dedup_initiator #(
  parameter int NUM_CLASSES = 27,
  parameter int SCORE_W     = 16,
  parameter int IDX_W       = 5,
  parameter int TIMEOUT     = 255
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_score_valid,
  input  logic [SCORE_W-1:0] i_score,
  output logic               o_score_ready,
  output logic               o_dedup_next,
  output logic [IDX_W-1:0]   o_tops      [0:2],
  output logic [IDX_W-1:0]   o_prev_tops [0:2],
  input  logic               i_dedup_finished,
  input  logic               i_dedup_next,
  output logic               o_char_valid,
  output logic [IDX_W-1:0]   o_char,
  input  logic               i_char_ready,
  output logic               o_timeout
);

  localparam int                WAIT_W      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_CLASSES - 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT    = 2'd2,
    S_EMIT    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     beat_q, beat_d;
  logic [2:0]           slot_vld_q, slot_vld_d;
  logic [IDX_W-1:0]     slot_idx_q   [0:2];
  logic [IDX_W-1:0]     slot_idx_d   [0:2];
  logic [SCORE_W-1:0]   slot_score_q [0:2];
  logic [SCORE_W-1:0]   slot_score_d [0:2];
  logic [IDX_W-1:0]     tops_q       [0:2];
  logic [IDX_W-1:0]     tops_d       [0:2];
  logic [IDX_W-1:0]     prev_tops_q  [0:2];
  logic [IDX_W-1:0]     prev_tops_d  [0:2];
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic                 char_valid_q, char_valid_d;
  logic [IDX_W-1:0]     char_q, char_d;
  logic                 timeout_q, timeout_d;

  // Slot contents after inserting the current beat (used only when a beat is accepted)
  logic [2:0]           ins_vld;
  logic [IDX_W-1:0]     ins_idx   [0:2];
  logic [SCORE_W-1:0]   ins_score [0:2];

  // Sorted insertion. Strict '>' lets an earlier (lower) index keep its rank on ties;
  // an empty slot accepts any score.
  always_comb begin
    ins_vld = slot_vld_q;
    for (int i = 0; i < 3; i++) begin
      ins_idx[i]   = slot_idx_q[i];
      ins_score[i] = slot_score_q[i];
    end
    if (!slot_vld_q[0] || (i_score > slot_score_q[0])) begin
      ins_vld      = {slot_vld_q[1], slot_vld_q[0], 1'b1};
      ins_idx[2]   = slot_idx_q[1];
      ins_score[2] = slot_score_q[1];
      ins_idx[1]   = slot_idx_q[0];
      ins_score[1] = slot_score_q[0];
      ins_idx[0]   = beat_q;
      ins_score[0] = i_score;
    end else if (!slot_vld_q[1] || (i_score > slot_score_q[1])) begin
      ins_vld      = {slot_vld_q[1], 1'b1, slot_vld_q[0]};
      ins_idx[2]   = slot_idx_q[1];
      ins_score[2] = slot_score_q[1];
      ins_idx[1]   = beat_q;
      ins_score[1] = i_score;
    end else if (!slot_vld_q[2] || (i_score > slot_score_q[2])) begin
      ins_vld[2]   = 1'b1;
      ins_idx[2]   = beat_q;
      ins_score[2] = i_score;
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    slot_vld_d   = slot_vld_q;
    wait_d       = wait_q;
    char_valid_d = char_valid_q;
    char_d       = char_q;
    timeout_d    = timeout_q;
    for (int i = 0; i < 3; i++) begin
      slot_idx_d[i]   = slot_idx_q[i];
      slot_score_d[i] = slot_score_q[i];
      tops_d[i]       = tops_q[i];
      prev_tops_d[i]  = prev_tops_q[i];
    end

    case (state_q)
      S_COLLECT: begin
        if (i_score_valid) begin
          slot_vld_d = ins_vld;
          for (int i = 0; i < 3; i++) begin
            slot_idx_d[i]   = ins_idx[i];
            slot_score_d[i] = ins_score[i];
          end
          if (beat_q == LAST_IDX) begin
            // o_tops is only published here so the checker sees a whole frame
            beat_d  = '0;
            state_d = S_REQ;
            for (int i = 0; i < 3; i++) tops_d[i] = ins_idx[i];
          end else begin
            beat_d = beat_q + IDX_W'(1);
          end
        end
      end

      S_REQ: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // A verdict arriving on the timeout cycle still takes priority
        if (i_dedup_finished) begin
          slot_vld_d = '0;
          if (i_dedup_next) begin
            state_d      = S_EMIT;
            char_valid_d = 1'b1;
            char_d       = tops_q[0];
            for (int i = 0; i < 3; i++) prev_tops_d[i] = tops_q[i];
          end else begin
            state_d = S_COLLECT;
          end
        end else if (wait_q == TIMEOUT_CNT) begin
          timeout_d  = 1'b1;
          slot_vld_d = '0;
          state_d    = S_COLLECT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_EMIT: begin
        if (i_char_ready) begin
          char_valid_d = 1'b0;
          slot_vld_d   = '0;
          state_d      = S_COLLECT;
        end
      end

      default: begin
        state_d    = S_COLLECT;
        slot_vld_d = '0;
        beat_d     = '0;
      end
    endcase
  end

  // Control and visible outputs: reset to a clean collecting state
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      state_q      <= S_COLLECT;
      beat_q       <= '0;
      slot_vld_q   <= '0;
      wait_q       <= '0;
      char_valid_q <= 1'b0;
      char_q       <= '0;
      timeout_q    <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        tops_q[i]      <= '0;
        prev_tops_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      slot_vld_q   <= slot_vld_d;
      wait_q       <= wait_d;
      char_valid_q <= char_valid_d;
      char_q       <= char_d;
      timeout_q    <= timeout_d;
      for (int i = 0; i < 3; i++) begin
        tops_q[i]      <= tops_d[i];
        prev_tops_q[i] <= prev_tops_d[i];
      end
    end
  end

  // Slot payload is qualified by slot_vld_q, so it needs no reset
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 3; i++) begin
      slot_idx_q[i]   <= slot_idx_d[i];
      slot_score_q[i] <= slot_score_d[i];
    end
  end

  assign o_score_ready  = (state_q == S_COLLECT);
  assign o_dedup_next   = (state_q == S_REQ);
  assign o_char_valid   = char_valid_q;
  assign o_char         = char_q;
  assign o_timeout      = timeout_q;
  assign o_tops[0]      = tops_q[0];
  assign o_tops[1]      = tops_q[1];
  assign o_tops[2]      = tops_q[2];
  assign o_prev_tops[0] = prev_tops_q[0];
  assign o_prev_tops[1] = prev_tops_q[1];
  assign o_prev_tops[2] = prev_tops_q[2];

endmodule

// File: tb/tb_top3_dedup_initiator.sv
`timescale 1ns/1ps
module tb_top3_dedup_initiator;

  localparam int NC = 27;
  localparam int SW = 16;
  localparam int IW = 5;
  localparam int TO = 255;

  logic          clk = 1'b0;
  logic          i_rst_n;
  logic          i_score_valid;
  logic [SW-1:0] i_score;
  logic          o_score_ready;
  logic          o_dedup_next;
  logic [IW-1:0] tops [0:2];
  logic [IW-1:0] prev [0:2];
  logic          i_dedup_finished;
  logic          i_dedup_next;
  logic          o_char_valid;
  logic [IW-1:0] o_char;
  logic          i_char_ready;
  logic          o_timeout;

  always #5 clk = ~clk;

  top3_dedup_initiator #(
    .NUM_CLASSES(NC), .SCORE_W(SW), .IDX_W(IW), .TIMEOUT(TO)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (i_rst_n),
    .i_score_valid   (i_score_valid),
    .i_score         (i_score),
    .o_score_ready   (o_score_ready),
    .o_dedup_next    (o_dedup_next),
    .o_tops          (tops),
    .o_prev_tops     (prev),
    .i_dedup_finished(i_dedup_finished),
    .i_dedup_next    (i_dedup_next),
    .o_char_valid    (o_char_valid),
    .o_char          (o_char),
    .i_char_ready    (i_char_ready),
    .o_timeout       (o_timeout)
  );

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [SW-1:0] scores   [NC];
  logic [IW-1:0] exp_tops [0:2];
  logic [IW-1:0] exp_out  [0:2];
  logic [IW-1:0] exp_prev [0:2];
  logic          exp_timeout;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic [IW-1:0] a, input logic [IW-1:0] b,
                                     input logic [IW-1:0] c);
    return 32'({a, b, c});
  endfunction

  // Top-3 by repeated selection of the maximum; the ascending scan with strict '>'
  // gives the lowest index on ties.
  task automatic model_top3();
    bit taken [NC];
    for (int k = 0; k < NC; k++) taken[k] = 1'b0;
    for (int r = 0; r < 3; r++) begin
      int best = -1;
      for (int k = 0; k < NC; k++)
        if (!taken[k] && (best < 0 || scores[k] > scores[best])) best = k;
      taken[best] = 1'b1;
      exp_tops[r] = IW'(best);
    end
  endtask

  task automatic junk_cycle();
    i_score_valid = 1'b1;
    i_score       = SW'($urandom);
    @(negedge clk);
  endtask

  task automatic send_frame(input bit gaps);
    for (int k = 0; k < NC; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      i_score_valid = 1'b1;
      i_score       = scores[k];
      chk("score_ready", 32'(o_score_ready), 32'd1);
      if (k == 13)
        chk("tops_hold_collect", pk(tops[0], tops[1], tops[2]),
            pk(exp_out[0], exp_out[1], exp_out[2]));
      @(negedge clk);
      i_score_valid = 1'b0;
    end
  endtask

  // mode 0 = checker says new, 1 = not new, 2 = checker silent
  task automatic run_frame(input int mode, input int hold, input int dly);
    model_top3();
    send_frame(1'b1);
    for (int i = 0; i < 3; i++) exp_out[i] = exp_tops[i];
    chk("req_pulse", 32'(o_dedup_next), 32'd1);
    chk("req_ready", 32'(o_score_ready), 32'd0);
    chk("tops", pk(tops[0], tops[1], tops[2]), pk(exp_tops[0], exp_tops[1], exp_tops[2]));
    chk("prev_at_req", pk(prev[0], prev[1], prev[2]), pk(exp_prev[0], exp_prev[1], exp_prev[2]));
    chk("timeout_flag", 32'(o_timeout), 32'(exp_timeout));
    @(negedge clk);
    chk("req_one_cycle", 32'(o_dedup_next), 32'd0);
    if (mode == 2) begin
      repeat (TO) junk_cycle();
      chk("timeout_not_yet", 32'(o_timeout), 32'(exp_timeout));
      chk("wait_ready", 32'(o_score_ready), 32'd0);
      @(negedge clk);
      i_score_valid = 1'b0;
      exp_timeout = 1'b1;
      chk("timeout_set", 32'(o_timeout), 32'd1);
      chk("timeout_ready", 32'(o_score_ready), 32'd1);
      chk("timeout_no_char", 32'(o_char_valid), 32'd0);
      chk("timeout_prev", pk(prev[0], prev[1], prev[2]),
          pk(exp_prev[0], exp_prev[1], exp_prev[2]));
    end else begin
      repeat (dly) junk_cycle();
      chk("wait_tops_stable", pk(tops[0], tops[1], tops[2]),
          pk(exp_tops[0], exp_tops[1], exp_tops[2]));
      chk("wait_prev_stable", pk(prev[0], prev[1], prev[2]),
          pk(exp_prev[0], exp_prev[1], exp_prev[2]));
      i_score_valid    = 1'b0;
      i_dedup_finished = 1'b1;
      i_dedup_next     = (mode == 0);
      @(negedge clk);
      i_dedup_finished = 1'b0;
      i_dedup_next     = 1'($urandom);
      if (mode == 0) begin
        for (int i = 0; i < 3; i++) exp_prev[i] = exp_tops[i];
        chk("char_valid", 32'(o_char_valid), 32'd1);
        chk("char", 32'(o_char), 32'(exp_tops[0]));
        chk("prev_commit", pk(prev[0], prev[1], prev[2]),
            pk(exp_prev[0], exp_prev[1], exp_prev[2]));
        chk("emit_ready", 32'(o_score_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
          junk_cycle();
          chk("hold_char_valid", 32'(o_char_valid), 32'd1);
          chk("hold_char", 32'(o_char), 32'(exp_tops[0]));
          chk("hold_ready", 32'(o_score_ready), 32'd0);
        end
        i_score_valid = 1'b0;
        i_char_ready  = 1'b1;
        @(negedge clk);
        i_char_ready  = 1'b0;
        chk("char_done", 32'(o_char_valid), 32'd0);
        chk("after_emit_ready", 32'(o_score_ready), 32'd1);
      end else begin
        chk("drop_no_char", 32'(o_char_valid), 32'd0);
        chk("drop_ready", 32'(o_score_ready), 32'd1);
        chk("drop_prev", pk(prev[0], prev[1], prev[2]),
            pk(exp_prev[0], exp_prev[1], exp_prev[2]));
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_tops"}, pk(tops[0], tops[1], tops[2]), 32'd0);
    chk({tag, "_prev"}, pk(prev[0], prev[1], prev[2]), 32'd0);
    chk({tag, "_req"}, 32'(o_dedup_next), 32'd0);
    chk({tag, "_char_valid"}, 32'(o_char_valid), 32'd0);
    chk({tag, "_char"}, 32'(o_char), 32'd0);
    chk({tag, "_timeout"}, 32'(o_timeout), 32'd0);
    chk({tag, "_ready"}, 32'(o_score_ready), 32'd1);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      exp_out[i]  = '0;
      exp_prev[i] = '0;
    end
    exp_timeout = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

  initial begin
    i_rst_n          = 1'b1;
    i_score_valid    = 1'b0;
    i_score          = '0;
    i_dedup_finished = 1'b0;
    i_dedup_next     = 1'b0;
    i_char_ready     = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    i_rst_n = 1'b0;
    @(negedge clk);

    // Ascending scores, accepted as new
    for (int k = 0; k < NC; k++) scores[k] = SW'(k);
    run_frame(0, 2, 3);
    // Same frame, rejected
    run_frame(1, 0, 5);
    // All equal: lowest indices win
    for (int k = 0; k < NC; k++) scores[k] = SW'(100);
    run_frame(0, 1, 0);
    // Two equal peaks plus zeros
    for (int k = 0; k < NC; k++) scores[k] = '0;
    scores[3] = SW'(500);
    scores[9] = SW'(500);
    run_frame(0, 0, 2);
    // Long back-pressure
    for (int k = 0; k < NC; k++) scores[k] = SW'($urandom);
    run_frame(0, 20, 4);
    // Silent checker
    for (int k = 0; k < NC; k++) scores[k] = SW'($urandom);
    run_frame(2, 0, 0);
    // Random frames with occasional narrow score ranges for ties
    for (int f = 0; f < 6; f++) begin
      bit narrow = 1'($urandom);
      for (int k = 0; k < NC; k++)
        scores[k] = narrow ? SW'($urandom_range(0, 7)) : SW'($urandom);
      run_frame(int'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 10)));
    end

    // Reset in the middle of the wait, then a late verdict
    for (int k = 0; k < NC; k++) scores[k] = SW'($urandom);
    send_frame(1'b0);
    chk("pre_reset_req", 32'(o_dedup_next), 32'd1);
    repeat (4) @(negedge clk);
    i_rst_n = 1'b1;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    i_rst_n          = 1'b0;
    i_dedup_finished = 1'b1;
    i_dedup_next     = 1'b1;
    @(negedge clk);
    i_dedup_finished = 1'b0;
    i_dedup_next     = 1'b0;
    check_reset_values("late_fin");
    clear_model();

    // Normal operation after reset
    for (int k = 0; k < NC; k++) scores[k] = SW'($urandom);
    run_frame(0, 1, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
